vector_dot_engine: RTL and testbench

//  Compute engine behind the RUN opcode of the TinyTapeout vector unit.
//  - Walks vector A and vector B, one 4-bit word pair per cycle, from the shared word memory.
//  - Multiply-accumulates the pairs into an 8-bit result.
//  - The host fabric writes the result into the two-word output slot and drives uo_out from it.
//  - Sits directly downstream of the opcode/memory front end, which issues start/clear.

---
 rtl/vector_dot_engine.sv | 91 +++++++++
 tb/tb_vector_dot_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vector_dot_engine.sv
// vector_dot_engine: multiply-accumulates A[i]*B[i] over vec_len word pairs; DOT_SATURATE_EN clamps the accumulator instead of wrapping
module vector_dot_engine #(
  parameter int WORD_BITS   = 4,
  parameter int VEC_LEN_MAX = 16,
  parameter int ACC_BITS    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           clear,
  input  logic [$clog2(VEC_LEN_MAX):0]   vec_len,
  output logic [$clog2(VEC_LEN_MAX)-1:0] rd_idx,
  input  logic [WORD_BITS-1:0]           rd_a,
  input  logic [WORD_BITS-1:0]           rd_b,
  output logic [ACC_BITS-1:0]            result,
  output logic                           result_we,
  output logic                           overflow,
  output logic [1:0]                     state
);
  localparam int IW = $clog2(VEC_LEN_MAX);
  localparam int LW = IW + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t st_q, st_n;
  logic [LW-1:0] len_q, len_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [ACC_BITS-1:0] acc_q, acc_n, result_n, prod;
  logic [ACC_BITS:0] sum;
  logic ovf_run_q, ovf_run_n, overflow_n, we_n, last;
  assign prod   = ACC_BITS'(rd_a) * ACC_BITS'(rd_b);
  assign sum    = {1'b0, acc_q} + {1'b0, prod};
  assign last   = {1'b0, idx_q} == len_q - LW'(1);
  assign rd_idx = st_q == RUN ? idx_q : '0;
  assign state  = st_q;
  always_comb begin
    st_n       = st_q;
    len_n      = len_q;
    idx_n      = idx_q;
    acc_n      = acc_q;
    ovf_run_n  = ovf_run_q;
    result_n   = result;
    overflow_n = overflow;
    we_n       = 1'b0;
    if (clear) begin
      st_n = IDLE;
    end else if (st_q == IDLE && start) begin
      len_n     = vec_len > LW'(VEC_LEN_MAX) ? LW'(VEC_LEN_MAX) : vec_len;
      idx_n     = '0;
      acc_n     = '0;
      ovf_run_n = 1'b0;
      st_n      = RUN;
    end else if (st_q == RUN && len_q == '0) begin
      result_n   = '0;
      overflow_n = 1'b0;
      we_n       = 1'b1;
      st_n       = DONE;
    end else if (st_q == RUN) begin
`ifdef DOT_SATURATE_EN
      acc_n = sum[ACC_BITS] ? '1 : sum[ACC_BITS-1:0];
`else
      acc_n = sum[ACC_BITS-1:0];
`endif
      ovf_run_n  = ovf_run_q | sum[ACC_BITS];
      idx_n      = last ? idx_q : idx_q + IW'(1);
      result_n   = last ? acc_n : result;
      overflow_n = last ? ovf_run_n : overflow;
      we_n       = last;
      st_n       = last ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      ovf_run_q <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      result_we <= 1'b0;
    end else begin
      st_q      <= st_n;
      len_q     <= len_n;
      idx_q     <= idx_n;
      acc_q     <= acc_n;
      ovf_run_q <= ovf_run_n;
      result    <= result_n;
      overflow  <= overflow_n;
      result_we <= we_n;
    end
  end
endmodule

// File: tb/tb_vector_dot_engine.sv
// tb_vector_dot_engine: scoreboard bench; expected {overflow,result} queued at start, checked on each result_we
module tb_vector_dot_engine;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
  logic [4:0] vec_len = '0;
  logic [3:0] rd_idx, rd_a, rd_b;
  logic [7:0] result;
  logic result_we, overflow;
  logic [1:0] state;
  logic [3:0] mem_a [16];
  logic [3:0] mem_b [16];
  logic [8:0] exp_q [$];
  logic [7:0] last_res;
  int total = 0, bad = 0, we_cnt = 0, w0;
  vector_dot_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .vec_len(vec_len),
    .rd_idx(rd_idx), .rd_a(rd_a), .rd_b(rd_b), .result(result),
    .result_we(result_we), .overflow(overflow), .state(state)
  );
  assign rd_a = mem_a[rd_idx];
  assign rd_b = mem_b[rd_idx];
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask
  function automatic logic [8:0] model(input int len);
    int l = len > 16 ? 16 : len;
    int acc = 0;
    logic o = 1'b0;
    for (int i = 0; i < l; i++) begin
      acc += int'(mem_a[i]) * int'(mem_b[i]);
      if (acc > 255) begin
        o = 1'b1;
`ifdef DOT_SATURATE_EN
        acc = 255;
`else
        acc -= 256;
`endif
      end
    end
    return {o, 8'(acc)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int len, input bit push);
    logic [8:0] e;
    vec_len = 5'(len);
    start = 1'b1;
    if (push) begin
      e = model(len);
      exp_q.push_back(e);
      last_res = e[7:0];
    end
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (state !== 2'd2 && n < 40) begin
      tick();
      n++;
    end
    check("done_timeout", state, 2);
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_idle", state, 0);
  endtask
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && result_we) begin
      we_cnt++;
      if (exp_q.size() == 0) check("we_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("result", result, e[7:0]);
        check("overflow", overflow, e[8]);
      end
    end
  end
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 4'(i + 1);
      mem_b[i] = 4'(i + 1);
    end
    #2;
    check("rst_state", state, 0);
    check("rst_idx", rd_idx, 0);
    check("rst_result", result, 0);
    check("rst_we", result_we, 0);
    check("rst_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();
    w0 = we_cnt;
    go(4, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_run", state, 1);
      check("t1_idx", rd_idx, i);
      tick();
    end
    check("t1_done", state, 2);
    check("t1_we", result_we, 1);
    check("t1_res30", result, 30);
    tick();
    check("t1_we_pulse", result_we, 0);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("t5_done_hold", state, 2);
    check("t1_we_count", we_cnt - w0, 1);
    do_clear();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 4'd15;
      mem_b[i] = 4'd15;
    end
    go(16, 1);
    wait_done();
`ifdef DOT_SATURATE_EN
    check("t2_res", result, 255);
`else
    check("t2_res", result, 16);
`endif
    check("t2_ovf", overflow, 1);
    do_clear();
    go(0, 1);
    check("t3_len0_run", state, 1);
    tick();
    check("t3_len0_done", state, 2);
    check("t3_len0_we", result_we, 1);
    check("t3_len0_ovf", overflow, 0);
    do_clear();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 4'($urandom_range(0, 15));
      mem_b[i] = 4'($urandom_range(0, 15));
    end
    go(20, 1);
    wait_done();
    do_clear();
    w0 = we_cnt;
    go(8, 0);
    tick();
    tick();
    check("t4_idx2", rd_idx, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_abort_idle", state, 0);
    check("t4_abort_idx", rd_idx, 0);
    check("t4_keep_res", result, last_res);
    tick();
    check("t4_no_we", we_cnt - w0, 0);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("t5_clear_wins", state, 0);
    go(8, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_state", state, 0);
    check("t6_rst_res", result, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_idx", rd_idx, 0);
    rst_n = 1'b1;
    tick();
    go(5, 1);
    repeat (5) tick();
    check("t6_fresh_done", state, 2);
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
